// File: rtl/sodor_mem_pkg.sv
// Shared types and helpers for the Sodor latency memory: access-type encoding,
// fill-LFSR polynomial, read-latency bounds and byte-lane load/store helpers.
package sodor_mem_pkg;

    typedef enum logic [2:0] {
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd5,
        MT_HU = 3'd6
    } mem_typ_e;

    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam int          RD_LAT_MIN = 1;
    localparam int          RD_LAT_MAX = 4;

    // Legal type and naturally aligned for its size.
    function automatic logic typ_ok(input logic [2:0] typ, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (typ)
            MT_B, MT_BU: ok = 1'b1;
            MT_H, MT_HU: ok = ~off[0];
            MT_W:        ok = (off == 2'd0);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] typ,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (typ)
            MT_B:    res = {{24{sh[7]}}, sh[7:0]};
            MT_BU:   res = {24'd0, sh[7:0]};
            MT_H:    res = {{16{sh[15]}}, sh[15:0]};
            MT_HU:   res = {16'd0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [2:0] typ, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] data;
        case (typ)
            MT_B, MT_BU: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                data = {24'd0, wdata[7:0]} << {off, 3'b000};
            end
            MT_H, MT_HU: begin
                mask = 32'h0000_FFFF << {off, 3'b000};
                data = {16'd0, wdata[15:0]} << {off, 3'b000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/sodor_mem_lfsr.sv
// 32-bit Galois LFSR producing fill values for never-written dmem words.
// Advances one step on each cycle en_i is high; state_o is the current value.
module sodor_mem_lfsr
    import sodor_mem_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2024,
    parameter logic [31:0] POLY = LFSR_POLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? POLY : 32'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sodor_lat_mem.sv
// Fixed-latency instruction/data memory for Sodor cores. Unwritten imem words are
// filled from gen_insn on first fetch, unwritten dmem words from an LFSR.
module sodor_lat_mem
    import sodor_mem_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_req_valid,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_resp_valid,
    output logic [DATA_W-1:0] imem_data,
    output logic              gen_insn_req,
    input  logic [DATA_W-1:0] gen_insn,
    input  logic              dmem_req_valid,
    input  logic              dmem_req_write_en,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic [DATA_W-1:0] dmem_req_data,
    input  logic [2:0]        dmem_req_bits_typ,
    output logic              dmem_resp_valid,
    output logic [DATA_W-1:0] dmem_resp_data,
    output logic              dmem_resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("sodor_lat_mem: DATA_W must be 32");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("sodor_lat_mem: RD_LAT out of range 1..4");
    end
    if (LFSR_SEED == 32'd0) begin : g_bad_seed
        $error("sodor_lat_mem: LFSR_SEED must be nonzero");
    end

    logic [DATA_W-1:0] imem_q [DEPTH];
    logic [DATA_W-1:0] dmem_q [DEPTH];
    logic [DEPTH-1:0]  ifill_q;
    logic [DEPTH-1:0]  dfill_q;

    // Only the word-index bits and the dmem byte offset select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[ADDR_W-1:DEPTH_LOG2+2], imem_addr[1:0],
                                dmem_req_addr[ADDR_W-1:DEPTH_LOG2+2]};

    logic [DEPTH_LOG2-1:0] i_idx;
    logic                  i_hit;
    logic [DATA_W-1:0]     i_rdata;

    assign i_idx        = imem_addr[DEPTH_LOG2+1:2];
    assign i_hit        = ifill_q[i_idx];
    assign gen_insn_req = rst_n & imem_req_valid & ~i_hit;
    assign i_rdata      = i_hit ? imem_q[i_idx] : gen_insn;

    logic [DEPTH_LOG2-1:0] d_idx;
    logic [1:0]            d_off;
    logic                  d_fire;
    logic                  d_filled;
    logic [DATA_W-1:0]     d_cur;
    logic                  d_wr_en;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;
    logic                  lfsr_en;
    logic [31:0]           lfsr_val;

    // d_cur is the word as the core would see it: stored value, or the fill value
    // that an unfilled word takes on at this access.
    always_comb begin
        d_idx    = dmem_req_addr[DEPTH_LOG2+1:2];
        d_off    = dmem_req_addr[1:0];
        d_fire   = dmem_req_valid & typ_ok(dmem_req_bits_typ, d_off);
        d_err    = dmem_req_valid & ~typ_ok(dmem_req_bits_typ, d_off);
        d_filled = dfill_q[d_idx];
        d_cur    = d_filled ? dmem_q[d_idx] : lfsr_val;
        d_wr_en  = d_fire & (dmem_req_write_en | ~d_filled);
        d_wdata  = dmem_req_write_en
                 ? store_merge(d_cur, dmem_req_data, dmem_req_bits_typ, d_off) : d_cur;
        d_rdata  = (d_fire & ~dmem_req_write_en)
                 ? load_extract(d_cur, dmem_req_bits_typ, d_off) : '0;
        // A full-word store overwrites every lane, so it never consumes a fill value.
        lfsr_en  = d_fire & ~d_filled & ~(dmem_req_write_en & (dmem_req_bits_typ == MT_W));
    end

    sodor_mem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (lfsr_en),
        .state_o(lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (gen_insn_req) imem_q[i_idx] <= gen_insn;
        if (d_wr_en)      dmem_q[d_idx] <= d_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifill_q <= '0;
            dfill_q <= '0;
        end else begin
            if (gen_insn_req) ifill_q[i_idx] <= 1'b1;
            if (d_wr_en)      dfill_q[d_idx] <= 1'b1;
        end
    end

    logic [RD_LAT-1:0] iv_q;
    logic [RD_LAT-1:0] dv_q;
    logic [RD_LAT-1:0] de_q;
    logic [DATA_W-1:0] id_q [RD_LAT];
    logic [DATA_W-1:0] dd_q [RD_LAT];

    // Data stages load only behind a valid entry so the last stage holds on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q <= '0;
            dv_q <= '0;
            de_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                id_q[i] <= '0;
                dd_q[i] <= '0;
            end
        end else begin
            iv_q[0] <= imem_req_valid;
            dv_q[0] <= dmem_req_valid;
            if (imem_req_valid) id_q[0] <= i_rdata;
            if (dmem_req_valid) begin
                dd_q[0] <= d_rdata;
                de_q[0] <= d_err;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                iv_q[i] <= iv_q[i-1];
                dv_q[i] <= dv_q[i-1];
                if (iv_q[i-1]) id_q[i] <= id_q[i-1];
                if (dv_q[i-1]) begin
                    dd_q[i] <= dd_q[i-1];
                    de_q[i] <= de_q[i-1];
                end
            end
        end
    end

    assign imem_resp_valid = iv_q[RD_LAT-1];
    assign imem_data       = id_q[RD_LAT-1];
    assign dmem_resp_valid = dv_q[RD_LAT-1];
    assign dmem_resp_data  = dd_q[RD_LAT-1];
    assign dmem_resp_err   = dv_q[RD_LAT-1] & de_q[RD_LAT-1];

endmodule
